// File: rtl/adc_fe_pkg.sv
// adc_fe_pkg: shared ADC front-end types and alignment defaults
package adc_fe_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_CHECK, S_SLIP, S_SETTLE, S_LOCKED, S_FAIL
  } align_state_t;
  localparam logic [7:0] FCO_PATTERN_DEF = 8'hF0;
  localparam int MAX_SLIPS_DEF = 8;
endpackage

// File: rtl/adc_align_ctrl.sv
// adc_align_ctrl: FCO frame alignment FSM driving bitslip until the frame word locks
module adc_align_ctrl
  import adc_fe_pkg::*;
#(
  parameter int FCO_W = 8,
  parameter logic [FCO_W-1:0] FCO_PATTERN = FCO_PATTERN_DEF,
  parameter int MATCH_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int MAX_SLIPS = MAX_SLIPS_DEF,
  parameter int SETTLE_CYC = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [FCO_W-1:0]                 fco_word,
  input  logic                             fco_valid,
  output logic                             bitslip,
  output logic                             fifo_flush,
  output logic                             dp_en,
  output logic                             locked,
  output logic                             fail,
  output logic                             busy,
  output logic [$clog2(MAX_SLIPS+1)-1:0]   slip_cnt
);
  localparam int SW = $clog2(MAX_SLIPS + 1);
  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam int TW = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0] SLIP_MAX = SW'(MAX_SLIPS);
  localparam logic [MW-1:0] MATCH_MAX = MW'(MATCH_COUNT);
  localparam logic [LW-1:0] LOSS_MAX = LW'(LOSS_COUNT);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
  align_state_t state, state_n;
  logic [MW-1:0] match_cnt, match_n;
  logic [LW-1:0] loss_cnt, loss_n;
  logic [TW-1:0] settle_cnt, settle_n;
  logic [SW-1:0] slip_n;
  logic hit;
  assign hit = fco_word == FCO_PATTERN;
  always_comb begin
    state_n = state;
    match_n = match_cnt;
    loss_n = loss_cnt;
    settle_n = settle_cnt;
    slip_n = slip_cnt;
    case (state)
      S_IDLE: state_n = start ? S_FLUSH : S_IDLE;
      S_FLUSH: state_n = S_CHECK;
      S_CHECK:
        if (fco_valid && hit) begin
          match_n = match_cnt + MW'(1);
          state_n = (match_n == MATCH_MAX) ? S_LOCKED : S_CHECK;
        end else if (fco_valid) begin
          match_n = '0;
          state_n = (slip_cnt == SLIP_MAX) ? S_FAIL : S_SLIP;
        end
      S_SLIP: begin
        slip_n = (slip_cnt == SLIP_MAX) ? slip_cnt : slip_cnt + SW'(1);
        settle_n = '0;
        state_n = S_SETTLE;
      end
      S_SETTLE: begin
        settle_n = settle_cnt + TW'(1);
        match_n = '0;
        state_n = (settle_cnt == SETTLE_LAST) ? S_CHECK : S_SETTLE;
      end
      S_LOCKED:
        if (start) state_n = S_FLUSH;
        else if (fco_valid) begin
          loss_n = hit ? '0 : loss_cnt + LW'(1);
          state_n = (loss_n == LOSS_MAX) ? S_FLUSH : S_LOCKED;
        end
      S_FAIL: state_n = start ? S_FLUSH : S_FAIL;
      default: state_n = S_IDLE;
    endcase
    // every path into FLUSH starts a fresh attempt with slip_cnt already zero
    if (state_n == S_FLUSH) begin
      match_n = '0;
      loss_n = '0;
      slip_n = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      match_cnt <= '0;
      loss_cnt <= '0;
      settle_cnt <= '0;
      slip_cnt <= '0;
      bitslip <= 1'b0;
      fifo_flush <= 1'b0;
      dp_en <= 1'b0;
      locked <= 1'b0;
      fail <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      match_cnt <= match_n;
      loss_cnt <= loss_n;
      settle_cnt <= settle_n;
      slip_cnt <= slip_n;
      bitslip <= state_n == S_SLIP;
      fifo_flush <= state_n == S_FLUSH;
      dp_en <= state_n == S_LOCKED;
      locked <= state_n == S_LOCKED;
      fail <= state_n == S_FAIL;
      busy <= state_n inside {S_FLUSH, S_CHECK, S_SLIP, S_SETTLE};
    end
  end
endmodule

// File: doc/adc_align_ctrl.md
ADC_ALIGN_CTRL -- requirements
Module: adc_align_ctrl

Interface
REQ-001 SHALL have parameter FCO_W, default 8, meaning the width of the parallel FCO frame word.
REQ-002 SHALL have parameter FCO_PATTERN, default 8'hF0, meaning the expected aligned FCO word.
REQ-003 SHALL have parameter MATCH_COUNT, default 4, meaning the number of consecutive matches required to lock.
REQ-004 SHALL have parameter LOSS_COUNT, default 3, meaning the number of consecutive mismatches in LOCKED that trigger retraining.
REQ-005 SHALL have parameter MAX_SLIPS, default 8, meaning the maximum number of bitslips per training attempt.
REQ-006 SHALL have parameter SETTLE_CYC, default 8, meaning the number of clk cycles ignored after each bitslip.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port start, input, 1 bit: a training request pulse.
REQ-010 SHALL have port fco_word, input, FCO_W bits: the captured FCO frame word.
REQ-011 SHALL have port fco_valid, input, 1 bit: qualifies fco_word for one cycle.
REQ-012 SHALL have port bitslip, output, 1 bit: a one-cycle slip pulse to the capture/assembler.
REQ-013 SHALL have port fifo_flush, output, 1 bit: a one-cycle flush request to the CDC FIFO write side.
REQ-014 SHALL have port dp_en, output, 1 bit: the datapath write enable, ANDed with word_valid at the FIFO.
REQ-015 SHALL have port locked, output, 1 bit: the alignment-achieved status.
REQ-016 SHALL have port fail, output, 1 bit: training exhausted MAX_SLIPS without lock.
REQ-017 SHALL have port busy, output, 1 bit: asserted high while in FLUSH, CHECK, SLIP or SETTLE.
REQ-018 SHALL have port slip_cnt, output, $clog2(MAX_SLIPS+1) bits: the number of slips issued in the current attempt.

Function
REQ-019 SHALL implement states IDLE, FLUSH, CHECK, SLIP, SETTLE, LOCKED and FAIL.
REQ-020 SHALL move IDLE->FLUSH on start; in all other cases, IDLE SHALL hold.
REQ-021 SHALL, in FLUSH, assert fifo_flush for exactly 1 cycle, clear slip_cnt, match_cnt and loss_cnt, then enter CHECK.
REQ-022 SHALL, in CHECK, sample only cycles with fco_valid=1; a match (fco_word==FCO_PATTERN) increments match_cnt.
REQ-023 SHALL, in CHECK, when match_cnt reaches MATCH_COUNT, enter LOCKED on the next cycle; lock latency is MATCH_COUNT valid matches plus 1 cycle.
REQ-024 SHALL, in CHECK, on a mismatch, clear match_cnt; if slip_cnt==MAX_SLIPS it enters FAIL, otherwise it enters SLIP.
REQ-025 SHALL, in SLIP, assert bitslip for exactly 1 cycle, increment slip_cnt (saturating at MAX_SLIPS), then enter SETTLE.
REQ-026 SHALL, in SETTLE, count SETTLE_CYC cycles while ignoring fco_valid, then enter CHECK with match_cnt=0.
REQ-027 SHALL, in LOCKED, hold locked=1 and dp_en=1; each valid mismatch increments loss_cnt and each valid match clears it.
REQ-028 SHALL, in LOCKED, when loss_cnt reaches LOSS_COUNT, deassert dp_en and locked in the same cycle the FSM enters FLUSH.
REQ-029 SHALL make start in LOCKED or FAIL re-enter FLUSH (forced retrain); start in FLUSH/CHECK/SLIP/SETTLE SHALL be ignored.
REQ-030 SHALL hold fail=1 in FAIL until start or rst; dp_en=0 and bitslip=0 in FAIL.
REQ-031 SHALL drive outputs as registered Moore outputs decoded from the state; bitslip and fifo_flush SHALL never be asserted in the same cycle.
REQ-032 SHALL treat fco_valid coincident with a state transition as belonging to the state being left; it is not carried forward.

Reset
REQ-033 SHALL, on rst=1 at a clk edge, enter IDLE and clear all counters; outputs bitslip, fifo_flush, dp_en, locked, fail, busy=0 and slip_cnt=0 on the following cycle.
REQ-034 SHALL, on rst mid-training or mid-LOCKED, abort immediately with no flush or slip pulse emitted.

Structure
REQ-035 SHALL place the state enum typedef and FCO_PATTERN/MAX_SLIPS defaults in shared package adc_fe_pkg.
REQ-036 SHALL be a single module with no sub-module; the counters and FSM are inline.

Verification
REQ-037 SHALL cover: fco_word=8'hF0 on every valid, start -> fifo_flush 1 cycle, no bitslip, locked after 4 valids, slip_cnt=0.
REQ-038 SHALL cover: a model that rotates the word per bitslip, initial offset 3 -> exactly 3 bitslip pulses each ≥SETTLE_CYC apart, then locked, slip_cnt=3.
REQ-039 SHALL cover: constant 8'h00 -> 8 slips, then fail=1, busy=0, dp_en=0; start -> FLUSH, slip_cnt=0.
REQ-040 SHALL cover: in LOCKED, 2 mismatches then 1 match then 2 mismatches -> stays locked; 3 consecutive mismatches -> dp_en=0, fifo_flush pulse, retrain.
REQ-041 SHALL cover: rst asserted during SETTLE -> next cycle IDLE, all outputs 0, no bitslip pulse.
REQ-042 SHALL cover: start pulsed during SETTLE -> ignored, training completes unchanged.
